// File: rtl/reg_scoreboard_pkg.sv
// Shared register-file definitions: default geometry plus the address and
// pending-mask types used by the scoreboard and the register file.
package reg_scoreboard_pkg;

  localparam int SB_ADDR_WIDTH  = 5;
  localparam int SB_NUM_REGS    = 2 ** SB_ADDR_WIDTH;
  localparam int SB_MAX_PENDING = 4;

  typedef logic [SB_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [SB_NUM_REGS-1:0]   pend_mask_t;

endpackage

// File: rtl/reg_hazard_check.sv
// Combinational issue gate: blocks on reset/flush, RAW and WAW hazards,
// and a full in-flight write table.
module reg_hazard_check
  import reg_scoreboard_pkg::*;
#(
  parameter  int ADDR_WIDTH  = SB_ADDR_WIDTH,
  parameter  int MAX_PENDING = SB_MAX_PENDING,
  localparam int NUM_REGS    = 2 ** ADDR_WIDTH,
  localparam int CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input  logic                  reset,
  input  logic                  flush,
  input  logic [NUM_REGS-1:0]   pending,
  input  logic [CNT_W-1:0]      pend_count,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic                  use_rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic                  use_rs2,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic                  wr_rd,
  output logic                  ready
);

  logic raw_rs1;
  logic raw_rs2;
  logic waw;
  logic full;
  logic writes_rd;

  // Register 0 is hardwired, so it never creates a hazard or uses a slot.
  assign writes_rd = wr_rd && (rd != '0);
  assign raw_rs1   = use_rs1 && (rs1 != '0) && pending[rs1];
  assign raw_rs2   = use_rs2 && (rs2 != '0) && pending[rs2];
  assign waw       = writes_rd && pending[rd];
  assign full      = writes_rd && (pend_count == CNT_W'(MAX_PENDING));

  assign ready = !(reset || flush || raw_rs1 || raw_rs2 || waw || full);

endmodule

// File: rtl/reg_scoreboard.sv
// In-order register scoreboard: tracks pending destination writes between
// issue and writeback, and flags writebacks to registers that were not pending.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter  int ADDR_WIDTH  = SB_ADDR_WIDTH,
  parameter  int MAX_PENDING = SB_MAX_PENDING,
  localparam int NUM_REGS    = 2 ** ADDR_WIDTH,
  localparam int CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_IssValid,
  input  logic [ADDR_WIDTH-1:0] i_IssRs1,
  input  logic [ADDR_WIDTH-1:0] i_IssRs2,
  input  logic                  i_IssUseRs1,
  input  logic                  i_IssUseRs2,
  input  logic [ADDR_WIDTH-1:0] i_IssRd,
  input  logic                  i_IssWrRd,
  output logic                  o_IssReady,
  input  logic                  i_WbValid,
  input  logic [ADDR_WIDTH-1:0] i_WbAddr,
  input  logic                  i_Flush,
  output logic [NUM_REGS-1:0]   o_Pending,
  output logic [CNT_W-1:0]      o_PendCount,
  output logic                  o_WbErr
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pend_next;
  logic [CNT_W-1:0]    pend_count;
  logic [CNT_W-1:0]    count_next;
  logic                wb_err;
  logic                set_en;
  logic                clr_en;
  logic                err_en;
  logic                wb_live;

  reg_hazard_check #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .MAX_PENDING (MAX_PENDING)
  ) u_hazard (
    .reset      (i_Reset),
    .flush      (i_Flush),
    .pending    (pending),
    .pend_count (pend_count),
    .rs1        (i_IssRs1),
    .use_rs1    (i_IssUseRs1),
    .rs2        (i_IssRs2),
    .use_rs2    (i_IssUseRs2),
    .rd         (i_IssRd),
    .wr_rd      (i_IssWrRd),
    .ready      (o_IssReady)
  );

  // WAW blocking guarantees set and clear never target the same register.
  assign set_en  = i_IssValid && o_IssReady && i_IssWrRd && (i_IssRd != '0);
  assign wb_live = i_WbValid && (i_WbAddr != '0);
  assign clr_en  = wb_live && pending[i_WbAddr];
  assign err_en  = wb_live && !pending[i_WbAddr];

  always_comb begin
    pend_next  = pending;
    count_next = pend_count;
    if (set_en)
      pend_next[i_IssRd] = 1'b1;
    if (clr_en)
      pend_next[i_WbAddr] = 1'b0;
    if (set_en && !clr_en)
      count_next = pend_count + CNT_W'(1);
    else if (!set_en && clr_en)
      count_next = pend_count - CNT_W'(1);
  end

  // Flush wins over any same-cycle issue, writeback or error report.
  always_ff @(posedge i_Clock) begin
    if (i_Reset || i_Flush) begin
      pending    <= '0;
      pend_count <= '0;
      wb_err     <= 1'b0;
    end else begin
      pending    <= pend_next;
      pend_count <= count_next;
      wb_err     <= err_en;
    end
  end

  assign o_Pending   = pending;
  assign o_PendCount = pend_count;
  assign o_WbErr     = wb_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard (ADDR_WIDTH=5, MAX_PENDING=4).
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  logic       i_Clock;
  logic       i_Reset;
  logic       i_IssValid;
  reg_addr_t  i_IssRs1;
  reg_addr_t  i_IssRs2;
  logic       i_IssUseRs1;
  logic       i_IssUseRs2;
  reg_addr_t  i_IssRd;
  logic       i_IssWrRd;
  logic       o_IssReady;
  logic       i_WbValid;
  reg_addr_t  i_WbAddr;
  logic       i_Flush;
  pend_mask_t o_Pending;
  logic [2:0] o_PendCount;
  logic       o_WbErr;

  int checks = 0;
  int errors = 0;

  reg_scoreboard #(
    .ADDR_WIDTH  (5),
    .MAX_PENDING (4)
  ) dut (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_IssValid  (i_IssValid),
    .i_IssRs1    (i_IssRs1),
    .i_IssRs2    (i_IssRs2),
    .i_IssUseRs1 (i_IssUseRs1),
    .i_IssUseRs2 (i_IssUseRs2),
    .i_IssRd     (i_IssRd),
    .i_IssWrRd   (i_IssWrRd),
    .o_IssReady  (o_IssReady),
    .i_WbValid   (i_WbValid),
    .i_WbAddr    (i_WbAddr),
    .i_Flush     (i_Flush),
    .o_Pending   (o_Pending),
    .o_PendCount (o_PendCount),
    .o_WbErr     (o_WbErr)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  // Drive every input at once, then let combinational outputs settle.
  task automatic applyStimulus(input logic reset, input logic flush,
                               input logic valid, input reg_addr_t rs1, input logic use1,
                               input reg_addr_t rs2, input logic use2,
                               input reg_addr_t rd, input logic wr,
                               input logic wbv, input reg_addr_t wba);
    i_Reset     = reset;
    i_Flush     = flush;
    i_IssValid  = valid;
    i_IssRs1    = rs1;
    i_IssUseRs1 = use1;
    i_IssRs2    = rs2;
    i_IssUseRs2 = use2;
    i_IssRd     = rd;
    i_IssWrRd   = wr;
    i_WbValid   = wbv;
    i_WbAddr    = wba;
    #1;
  endtask

  task automatic tick();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset, with an issue attempt that must be ignored.
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 5, 1, 0, 0);
    checkOutput("reset_ready", 32'(o_IssReady), 32'd0);
    tick();
    tick();
    checkOutput("reset_pending", o_Pending, 32'h0);
    checkOutput("reset_count", 32'(o_PendCount), 32'd0);
    checkOutput("reset_wberr", 32'(o_WbErr), 32'd0);

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("idle_ready", 32'(o_IssReady), 32'd1);

    // Issue Rd=5.
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 5, 1, 0, 0);
    checkOutput("issue5_ready", 32'(o_IssReady), 32'd1);
    tick();
    checkOutput("issue5_pending", o_Pending, 32'h0000_0020);
    checkOutput("issue5_count", 32'(o_PendCount), 32'd1);

    applyStimulus(0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rs1_unused_ready", 32'(o_IssReady), 32'd1);

    // RAW on Rs1=5 with the writeback of 5 in the same cycle: no bypass.
    applyStimulus(0, 0, 1, 5, 1, 0, 0, 6, 1, 1, 5);
    checkOutput("raw_wb_same_cycle", 32'(o_IssReady), 32'd0);
    tick();
    checkOutput("wb5_pending", o_Pending, 32'h0);
    checkOutput("wb5_count", 32'(o_PendCount), 32'd0);
    checkOutput("wb5_no_err", 32'(o_WbErr), 32'd0);
    applyStimulus(0, 0, 0, 5, 1, 0, 0, 6, 1, 0, 0);
    checkOutput("raw_released", 32'(o_IssReady), 32'd1);

    // Fill the table with Rd=1..4.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 0, 1, 0, 0, 0, 0, reg_addr_t'(i), 1, 0, 0);
      tick();
    end
    checkOutput("fill_pending", o_Pending, 32'h0000_001E);
    checkOutput("fill_count", 32'(o_PendCount), 32'd4);

    applyStimulus(0, 0, 1, 0, 0, 0, 0, 6, 1, 0, 0);
    checkOutput("cap_stall", 32'(o_IssReady), 32'd0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 6, 0, 0, 0);
    checkOutput("cap_nowrite_ready", 32'(o_IssReady), 32'd1);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("cap_rd0_ready", 32'(o_IssReady), 32'd1);
    tick();
    checkOutput("rd0_pending", o_Pending, 32'h0000_001E);
    checkOutput("rd0_count", 32'(o_PendCount), 32'd4);

    applyStimulus(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
    checkOutput("raw_rs2", 32'(o_IssReady), 32'd0);

    // Drain register 4, then WAW on 3 with a free slot.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
    tick();
    checkOutput("wb4_pending", o_Pending, 32'h0000_000E);
    checkOutput("wb4_count", 32'(o_PendCount), 32'd3);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 3, 1, 0, 0);
    checkOutput("waw_stall", 32'(o_IssReady), 32'd0);

    // Issue Rd=7 together with writeback of 3.
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 7, 1, 1, 3);
    checkOutput("setclr_ready", 32'(o_IssReady), 32'd1);
    tick();
    checkOutput("setclr_pending", o_Pending, 32'h0000_0086);
    checkOutput("setclr_count", 32'(o_PendCount), 32'd3);
    checkOutput("setclr_no_err", 32'(o_WbErr), 32'd0);

    // Illegal writeback to 9, then a silent writeback to 0.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
    tick();
    checkOutput("wb9_err", 32'(o_WbErr), 32'd1);
    checkOutput("wb9_pending", o_Pending, 32'h0000_0086);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("wb9_err_one_cycle", 32'(o_WbErr), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    checkOutput("wb0_no_err", 32'(o_WbErr), 32'd0);
    checkOutput("wb0_count", 32'(o_PendCount), 32'd3);

    // Flush with a same-cycle issue of Rd=8 and an illegal writeback.
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 8, 1, 1, 9);
    checkOutput("flush_ready", 32'(o_IssReady), 32'd0);
    tick();
    checkOutput("flush_pending", o_Pending, 32'h0);
    checkOutput("flush_count", 32'(o_PendCount), 32'd0);
    checkOutput("flush_no_err", 32'(o_WbErr), 32'd0);

    // Rebuild two entries, then reset mid-stream with an issue of Rd=12.
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 10, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 11, 1, 0, 0);
    tick();
    checkOutput("rebuild_pending", o_Pending, 32'h0000_0C00);
    checkOutput("rebuild_count", 32'(o_PendCount), 32'd2);
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 12, 1, 0, 0);
    checkOutput("midreset_ready", 32'(o_IssReady), 32'd0);
    tick();
    checkOutput("midreset_pending", o_Pending, 32'h0);
    checkOutput("midreset_count", 32'(o_PendCount), 32'd0);

    // A late writeback to a discarded entry is now illegal.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10);
    tick();
    checkOutput("post_reset_wb_err", 32'(o_WbErr), 32'd1);
    checkOutput("post_reset_pending", o_Pending, 32'h0);

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, register address width; NUM_REGS = 2**ADDR_WIDTH.
REQ-002 Parameter MAX_PENDING, default 4, maximum in-flight register writes (1..NUM_REGS-1).
REQ-003 i_Clock  in  1  clock; all state updates on rising edge.
REQ-004 i_Reset  in  1  reset, synchronous, active-high.
REQ-005 i_IssValid  in  1  decode stage presents an instruction for issue.
REQ-006 i_IssRs1, i_IssRs2  in  ADDR_WIDTH  source register addresses.
REQ-007 i_IssUseRs1, i_IssUseRs2  in  1  the corresponding source is actually read.
REQ-008 i_IssRd  in  ADDR_WIDTH  destination register address.
REQ-009 i_IssWrRd  in  1  the instruction writes i_IssRd.
REQ-010 o_IssReady  out  1  issue permitted this cycle; issue fires on i_IssValid & o_IssReady.
REQ-011 i_WbValid  in  1  writeback completes this cycle; same cycle as the register-file write enable.
REQ-012 i_WbAddr  in  ADDR_WIDTH  writeback destination.
REQ-013 i_Flush  in  1  discard all in-flight writes.
REQ-014 o_Pending  out  NUM_REGS  per-register pending mask; bit 0 is always 0.
REQ-015 o_PendCount  out  $clog2(MAX_PENDING+1)  number of pending registers.
REQ-016 o_WbErr  out  1  one-cycle pulse, registered, on an illegal writeback.

Function
REQ-017 o_IssReady SHALL be 0 while i_Reset or i_Flush is high.
REQ-018 RAW hazard: o_IssReady SHALL be 0 if (i_IssUseRs1 & i_IssRs1!=0 & o_Pending[i_IssRs1]) or the same condition holds for Rs2.
REQ-019 WAW hazard: o_IssReady SHALL be 0 if i_IssWrRd & i_IssRd!=0 & o_Pending[i_IssRd].
REQ-020 Capacity: o_IssReady SHALL be 0 if i_IssWrRd & i_IssRd!=0 & o_PendCount==MAX_PENDING.
REQ-021 Otherwise o_IssReady SHALL be 1; it is combinational and does not depend on i_IssValid.
REQ-022 A writeback to a register in the same cycle does not clear its hazard: there is no bypass, and the register-file data is visible only from the next cycle.
REQ-023 On a fired issue with i_IssWrRd=1 and i_IssRd!=0, o_Pending[i_IssRd] SHALL be set at the next edge.
REQ-024 Issue with i_IssRd==0 or i_IssWrRd==0 SHALL change no state.
REQ-025 On i_WbValid with i_WbAddr!=0 and o_Pending[i_WbAddr]=1, that bit SHALL be cleared at the next edge.
REQ-026 i_WbValid with i_WbAddr==0 SHALL be ignored silently.
REQ-027 i_WbValid to a non-pending nonzero register SHALL leave state unchanged and pulse o_WbErr for one cycle.
REQ-028 Simultaneous issue-set and writeback-clear of different registers SHALL both take effect; o_PendCount stays unchanged.
REQ-029 Issue-set and writeback-clear of the same register cannot occur together, because WAW (REQ-019) blocks it.
REQ-030 o_PendCount SHALL increment on each counted set, decrement on each clear, and stay equal to popcount(o_Pending) at all times.
REQ-031 i_Flush SHALL clear o_Pending and o_PendCount at the next edge and override a same-cycle issue and writeback; o_WbErr SHALL not pulse during flush.

Reset
REQ-032 While i_Reset is high, o_Pending, o_PendCount and o_WbErr SHALL be 0 at the next edge, and o_IssReady SHALL be 0.
REQ-033 Reset mid-operation SHALL discard all pending state; writebacks arriving after reset release fall under REQ-027.

Structure
REQ-034 The shared package SHALL hold ADDR_WIDTH defaults, the register-address typedef and the pending-mask typedef, common with the register file.
REQ-035 One sub-module, reg_hazard_check, SHALL contain the combinational RAW/WAW/capacity logic; state lives in reg_scoreboard.

Verification
REQ-036 After reset: issue Rd=5 -> o_Pending[5]=1, o_PendCount=1; next issue with Rs1=5 used -> o_IssReady=0.
REQ-037 Writeback to 5 while Rs1=5 is waiting -> o_IssReady stays 0 that cycle and becomes 1 the following cycle.
REQ-038 Issue Rd=1,2,3,4 with MAX_PENDING=4 -> issue with Rd=6 is stalled, while issue with Rd=0 or WrRd=0 is ready.
REQ-039 Same cycle: issue Rd=7 and writeback to 3 (pending) -> Pending[7]=1, Pending[3]=0, count unchanged.
REQ-040 Writeback to 9 (not pending) -> o_WbErr=1 for exactly one cycle; writeback to 0 -> no pulse.
REQ-041 With 3 pending: assert i_Flush together with an issue of Rd=8 -> o_Pending=0, o_PendCount=0, Rd 8 not set; reset mid-stream gives the same result.
